btb_update_ctrl: RTL and testbench

- Sequences EX-stage branch-resolution updates into the BTB's single write/update port.
- Buffers updates in a small FIFO and issues at most one per cycle.
- Inserts a one-cycle bubble between back-to-back updates to the same set, so each read-modify-write of set data and LRU sees the previous write.
- Runs an invalidate sweep over all sets on flush.

---
 rtl/btb_update_ctrl.sv | 174 +++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues resolved-branch updates from EX and feeds them to
// the BTB's single update port, one per cycle. A same-set update directly
// following another is held back one cycle so the BTB's read-modify-write of
// set data and LRU observes the preceding write. A flush request discards
// everything queued and sweeps an invalidate across all sets.
module btb_update_ctrl #(
    parameter int DEPTH    = 4,
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    input  logic [31:0]              req_target,
    input  logic                     req_mispredicted,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     btb_update,
    output logic [31:0]              btb_update_pc,
    output logic [31:0]              btb_update_target,
    output logic                     btb_mispredicted,
    output logic                     btb_inv,
    output logic [INDEX_W-1:0]       btb_inv_index,
    output logic [$clog2(DEPTH):0]   pending_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                upd_q, upd_d;
    logic [31:0]         upd_pc_q, upd_pc_d;
    logic [31:0]         upd_tgt_q, upd_tgt_d;
    logic                upd_mis_q, upd_mis_d;
    logic                inv_q, inv_d;
    logic [INDEX_W-1:0]  inv_idx_q, inv_idx_d;
    logic                busy_q, busy_d;

    // Entry storage; no reset needed since occupancy alone defines validity.
    logic [31:0] fifo_pc  [DEPTH];
    logic [31:0] fifo_tgt [DEPTH];
    logic        fifo_mis [DEPTH];

    logic [31:0]        head_pc;
    logic [INDEX_W-1:0] head_idx;
    logic               hazard;
    logic               push;
    logic               pop;

    assign head_pc  = fifo_pc[rd_ptr_q];
    assign head_idx = head_pc[INDEX_W+1:2];
    // The update in flight targets the same set as the head: wait one cycle.
    assign hazard   = upd_q && (head_idx == upd_pc_q[INDEX_W+1:2]);

    // A full FIFO refuses even when a pop happens this edge (no same-cycle refill).
    assign req_ready = (count_q < CW'(DEPTH)) && (state_q != ST_FLUSH) && !flush_req;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ST_IDLE) && !flush_req && (count_q != '0) && !hazard;

    // Write accepted updates at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]  <= req_pc;
            fifo_tgt[wr_ptr_q] <= req_target;
            fifo_mis[wr_ptr_q] <= req_mispredicted;
        end
    end

    // Next-state, FIFO bookkeeping and registered BTB-port outputs.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        upd_d     = 1'b0;
        upd_pc_d  = upd_pc_q;
        upd_tgt_d = upd_tgt_q;
        upd_mis_d = upd_mis_q;
        inv_d     = inv_q;
        inv_idx_d = inv_idx_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d   = ST_FLUSH;
                    rd_ptr_d  = '0;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    inv_d     = 1'b1;
                    inv_idx_d = '0;
                    busy_d    = 1'b1;
                end else begin
                    if (pop) begin
                        upd_d     = 1'b1;
                        upd_pc_d  = head_pc;
                        upd_tgt_d = fifo_tgt[rd_ptr_q];
                        upd_mis_d = fifo_mis[rd_ptr_q];
                        rd_ptr_d  = rd_ptr_q + PW'(1);
                    end
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    inv_idx_d = '0;
                end else if (inv_idx_q == LAST_SET) begin
                    state_d   = ST_IDLE;
                    inv_d     = 1'b0;
                    inv_idx_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    inv_idx_d = inv_idx_q + INDEX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset to the idle, empty condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            upd_q     <= 1'b0;
            upd_pc_q  <= '0;
            upd_tgt_q <= '0;
            upd_mis_q <= 1'b0;
            inv_q     <= 1'b0;
            inv_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            upd_q     <= upd_d;
            upd_pc_q  <= upd_pc_d;
            upd_tgt_q <= upd_tgt_d;
            upd_mis_q <= upd_mis_d;
            inv_q     <= inv_d;
            inv_idx_q <= inv_idx_d;
            busy_q    <= busy_d;
        end
    end

    assign btb_update        = upd_q;
    assign btb_update_pc     = upd_pc_q;
    assign btb_update_target = upd_tgt_q;
    assign btb_mispredicted  = upd_mis_q;
    assign btb_inv           = inv_q;
    assign btb_inv_index     = inv_idx_q;
    assign flush_busy        = busy_q;
    assign pending_count     = count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: directed vector table, multi-cycle corner
// sequences, and random traffic against a queue-based reference model.
module tb_btb_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_target;
    logic        req_mispredicted;
    logic        flush_req;
    logic        flush_busy;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic        btb_mispredicted;
    logic        btb_inv;
    logic [2:0]  btb_inv_index;
    logic [2:0]  pending_count;

    btb_update_ctrl #(.DEPTH(4), .NUM_SETS(8), .INDEX_W(3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_pc            (req_pc),
        .req_target        (req_target),
        .req_mispredicted  (req_mispredicted),
        .flush_req         (flush_req),
        .flush_busy        (flush_busy),
        .btb_update        (btb_update),
        .btb_update_pc     (btb_update_pc),
        .btb_update_target (btb_update_target),
        .btb_mispredicted  (btb_mispredicted),
        .btb_inv           (btb_inv),
        .btb_inv_index     (btb_inv_index),
        .pending_count     (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending queue plus the observable port values.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        mis;
    } ent_t;
    ent_t        mq[$];
    logic        m_upd;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_mis;
    logic        m_inv;
    int          m_idx;
    logic        m_busy;
    logic        last_ready;
    logic        last_accept;

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_upd = 0; m_pc = 0; m_tgt = 0; m_mis = 0;
        m_inv = 0; m_idx = 0; m_busy = 0;
    endtask

    task automatic check_model();
        chk("btb_update", {31'd0, btb_update}, {31'd0, m_upd});
        chk("btb_update_pc", btb_update_pc, m_pc);
        chk("btb_update_target", btb_update_target, m_tgt);
        chk("btb_mispredicted", {31'd0, btb_mispredicted}, {31'd0, m_mis});
        chk("btb_inv", {31'd0, btb_inv}, {31'd0, m_inv});
        chk("btb_inv_index", {29'd0, btb_inv_index}, 32'(m_idx));
        chk("flush_busy", {31'd0, flush_busy}, {31'd0, m_busy});
        chk("pending_count", {29'd0, pending_count}, 32'(mq.size()));
    endtask

    // One clock cycle: drive inputs, check req_ready, advance model and DUT,
    // then compare the registered outputs on the falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic mis, input logic fl);
        logic exp_ready;
        ent_t e;
        req_valid = v; req_pc = pc; req_target = tgt;
        req_mispredicted = mis; flush_req = fl;
        #1;
        exp_ready = (mq.size() < 4) && !m_busy && !fl;
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        last_ready  = req_ready;
        last_accept = v && exp_ready;
        if (!m_busy) begin
            if (fl) begin
                mq.delete();
                m_upd = 0; m_inv = 1; m_idx = 0; m_busy = 1;
            end else begin
                if (mq.size() > 0 && !(m_upd && set_of(mq[0].pc) == set_of(m_pc))) begin
                    e = mq.pop_front();
                    m_pc = e.pc; m_tgt = e.tgt; m_mis = e.mis; m_upd = 1;
                end else begin
                    m_upd = 0;
                end
                if (last_accept) begin
                    e.pc = pc; e.tgt = tgt; e.mis = mis;
                    mq.push_back(e);
                end
            end
        end else begin
            m_upd = 0;
            if (fl) m_idx = 0;
            else if (m_idx == 7) begin m_inv = 0; m_idx = 0; m_busy = 0; end
            else m_idx++;
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        mis;
        logic        exp_ready;
        logic        exp_upd;
        logic [31:0] exp_pc;
        logic [31:0] exp_tgt;
        logic        exp_mis;
        int          exp_cnt;
    } vec_t;
    vec_t tbl[13];

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic mis, input logic er, input logic eu,
                                input logic [31:0] epc, input logic [31:0] etgt,
                                input logic emis, input int ec);
        vec_t r;
        r.v = v; r.pc = pc; r.tgt = tgt; r.mis = mis; r.exp_ready = er;
        r.exp_upd = eu; r.exp_pc = epc; r.exp_tgt = etgt; r.exp_mis = emis; r.exp_cnt = ec;
        return r;
    endfunction

    logic [31:0] issued[$];
    int          n_acc;
    int          max_cnt;
    bit          saw_not_ready;
    int          inv_cycles;
    int          busy_cycles;
    bit          ready_in_sweep;
    bit          upd_in_sweep;
    bit          idx_order_ok;
    bit          restarted;
    logic        fl;

    initial begin
        rst_n = 0; req_valid = 0; req_pc = 0; req_target = 0;
        req_mispredicted = 0; flush_req = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_btb_update", {31'd0, btb_update}, 32'd0);
        chk("reset_pending", {29'd0, pending_count}, 32'd0);
        chk("reset_busy", {31'd0, flush_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        check_model();

        // Directed vectors: single push latency, back-to-back, same-set bubble.
        tbl[0]  = mk(1, 32'h1004, 32'h2000, 1, 1, 0, 32'h0,    32'h0,    0, 1);
        tbl[1]  = mk(0, 32'h0,    32'h0,    0, 1, 1, 32'h1004, 32'h2000, 1, 0);
        tbl[2]  = mk(0, 32'h0,    32'h0,    0, 1, 0, 32'h1004, 32'h2000, 1, 0);
        tbl[3]  = mk(1, 32'h100,  32'h1100, 0, 1, 0, 32'h1004, 32'h2000, 1, 1);
        tbl[4]  = mk(1, 32'h104,  32'h1104, 0, 1, 1, 32'h100,  32'h1100, 0, 1);
        tbl[5]  = mk(1, 32'h108,  32'h1108, 0, 1, 1, 32'h104,  32'h1104, 0, 1);
        tbl[6]  = mk(0, 32'h0,    32'h0,    0, 1, 1, 32'h108,  32'h1108, 0, 0);
        tbl[7]  = mk(0, 32'h0,    32'h0,    0, 1, 0, 32'h108,  32'h1108, 0, 0);
        tbl[8]  = mk(1, 32'h100,  32'h1100, 0, 1, 0, 32'h108,  32'h1108, 0, 1);
        tbl[9]  = mk(1, 32'h120,  32'h1120, 0, 1, 1, 32'h100,  32'h1100, 0, 1);
        tbl[10] = mk(0, 32'h0,    32'h0,    0, 1, 0, 32'h100,  32'h1100, 0, 1);
        tbl[11] = mk(0, 32'h0,    32'h0,    0, 1, 1, 32'h120,  32'h1120, 0, 0);
        tbl[12] = mk(0, 32'h0,    32'h0,    0, 1, 0, 32'h120,  32'h1120, 0, 0);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].tgt, tbl[i].mis, 1'b0);
            chk($sformatf("vec%0d_ready", i), {31'd0, last_ready}, {31'd0, tbl[i].exp_ready});
            chk($sformatf("vec%0d_upd", i), {31'd0, btb_update}, {31'd0, tbl[i].exp_upd});
            chk($sformatf("vec%0d_pc", i), btb_update_pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_tgt", i), btb_update_target, tbl[i].exp_tgt);
            chk($sformatf("vec%0d_mis", i), {31'd0, btb_mispredicted}, {31'd0, tbl[i].exp_mis});
            chk($sformatf("vec%0d_cnt", i), {29'd0, pending_count}, 32'(tbl[i].exp_cnt));
        end

        // Same-set stream fills the FIFO; drain must return every entry in order.
        n_acc = 0; max_cnt = 0; saw_not_ready = 0;
        issued.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h100, 32'h5000 + 32'(n_acc * 4), 1'b0, 1'b0);
            if (last_accept) n_acc++;
            if (!last_ready) saw_not_ready = 1;
            if (btb_update) issued.push_back(btb_update_target);
            if (int'(pending_count) > max_cnt) max_cnt = int'(pending_count);
        end
        for (int i = 0; i < 12; i++) begin
            idle();
            if (btb_update) issued.push_back(btb_update_target);
        end
        chk("fill_max_pending", 32'(max_cnt), 32'd4);
        chk("fill_saw_not_ready", {31'd0, saw_not_ready}, 32'd1);
        chk("fill_issued_count", 32'(issued.size()), 32'(n_acc));
        for (int i = 0; i < issued.size(); i++)
            chk($sformatf("fill_order%0d", i), issued[i], 32'h5000 + 32'(i * 4));

        // Flush with entries queued: full 8-set sweep.
        step(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h120, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h140, 32'h3, 1'b0, 1'b0);
        step(1'b1, 32'h160, 32'h4, 1'b0, 1'b1);
        chk("flush_pending_zero", {29'd0, pending_count}, 32'd0);
        inv_cycles = 0; busy_cycles = 0; ready_in_sweep = 0; upd_in_sweep = 0; idx_order_ok = 1;
        for (int k = 0; k < 20 && btb_inv; k++) begin
            if (int'(btb_inv_index) != inv_cycles) idx_order_ok = 0;
            inv_cycles++;
            if (flush_busy) busy_cycles++;
            if (btb_update) upd_in_sweep = 1;
            step(1'b1, 32'h200, 32'h9, 1'b0, 1'b0);
            if (last_ready && btb_inv) ready_in_sweep = 1;
            if (k == 0 && last_ready) ready_in_sweep = 1;
        end
        chk("sweep_inv_cycles", 32'(inv_cycles), 32'd8);
        chk("sweep_busy_cycles", 32'(busy_cycles), 32'd8);
        chk("sweep_index_order", {31'd0, idx_order_ok}, 32'd1);
        chk("sweep_no_ready", {31'd0, ready_in_sweep}, 32'd0);
        chk("sweep_no_update", {31'd0, upd_in_sweep}, 32'd0);
        repeat (3) idle();

        // Flush re-asserted while index 5 is presented restarts the sweep.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        inv_cycles = 0; restarted = 0;
        for (int k = 0; k < 40 && btb_inv; k++) begin
            inv_cycles++;
            fl = (btb_inv_index == 3'd5) && !restarted;
            if (fl) restarted = 1;
            step(1'b0, 32'h0, 32'h0, 1'b0, fl);
        end
        chk("restart_inv_cycles", 32'(inv_cycles), 32'd14);
        repeat (2) idle();

        // Reset in the middle of a sweep.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 20 && btb_inv_index != 3'd3; k++) idle();
        chk("pre_reset_index", {29'd0, btb_inv_index}, 32'd3);
        #2 rst_n = 0;
        #1;
        chk("rst_inv", {31'd0, btb_inv}, 32'd0);
        chk("rst_inv_index", {29'd0, btb_inv_index}, 32'd0);
        chk("rst_busy", {31'd0, flush_busy}, 32'd0);
        chk("rst_update_pc", btb_update_pc, 32'd0);
        chk("rst_update_target", btb_update_target, 32'd0);
        chk("rst_pending", {29'd0, pending_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0,
                 32'h1000 | ($urandom & 32'h0000_003C),
                 $urandom,
                 1'($urandom % 2),
                 ($urandom % 60) == 0);
        end
        repeat (12) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
